// File: rtl/sampler_capture_ctrl.sv
// Capture sequencer and interrupt controller for the sampler/FIFO datapath.
// Paces FIFO writes with a programmable period/count and raises sticky, ackable interrupts.
module sampler_capture_ctrl #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 16,
  parameter int LVL_WIDTH = 10
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [DIV_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  input  logic [LVL_WIDTH-1:0] cfg_thresh,
  input  logic                 fifo_full,
  input  logic [LVL_WIDTH-1:0] fifo_level,
  output logic                 fifo_wr_en,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] samples_done,
  input  logic [2:0]           intr_en,
  input  logic [2:0]           intr_ack,
  input  logic                 global_en,
  output logic [2:0]           intr_pending,
  output logic                 irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = DIV_WIDTH'(0);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIV_WIDTH-1:0] r_period;
  logic [DIV_WIDTH-1:0] r_div;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_samples;
  logic [2:0]           r_status;
  logic                 r_lvl_ge;
  logic                 r_irq;

  logic                 w_accept_start;
  logic                 w_tick;
  logic                 w_strobe;
  logic                 w_drop;
  logic                 w_last;
  logic                 w_lvl_ge;
  logic [CNT_WIDTH-1:0] w_samples_inc;
  logic [2:0]           w_status_set;

  // Tick/strobe decode and next-state selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_accept_start = cfg_start && !cfg_abort && (r_state == S_IDLE);
    w_tick         = (r_state == S_RUN) && (r_div == DIV_ZERO);
    // An aborting cycle never writes, even if the divider expires on it.
    w_strobe       = w_tick && !fifo_full && !cfg_abort;
    w_drop         = w_tick && fifo_full && !cfg_abort;
    w_samples_inc  = r_samples + CNT_ONE;
    w_last         = w_strobe && (r_count != CNT_ZERO) && (w_samples_inc == r_count);
    w_lvl_ge       = (fifo_level >= cfg_thresh);
    w_status_set   = {w_drop, w_lvl_ge && !r_lvl_ge, r_state == S_DONE};
    case (r_state)
      S_IDLE: begin
        if (w_accept_start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (cfg_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Run sequencing registers: state, latched config, divider and sample counter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state   <= S_IDLE;
      r_period  <= DIV_ZERO;
      r_div     <= DIV_ZERO;
      r_count   <= CNT_ZERO;
      r_samples <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept_start) begin
        r_period  <= cfg_period;
        r_count   <= cfg_count;
        r_div     <= cfg_period;
        r_samples <= CNT_ZERO;
      end else if (r_state == S_RUN) begin
        r_div <= w_tick ? r_period : (r_div - DIV_ONE);
        if (w_strobe) begin
          r_samples <= w_samples_inc;
        end else begin
          r_samples <= r_samples;
        end
      end else begin
        r_div <= r_div;
      end
    end
  end

  // Sticky status (set beats ack), threshold edge history and registered irq.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_status <= 3'b000;
      r_lvl_ge <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_status <= (r_status & ~intr_ack) | w_status_set;
      r_lvl_ge <= w_lvl_ge;
      r_irq    <= global_en & (|(r_status & intr_en));
    end
  end

  assign fifo_wr_en   = w_strobe;
  assign busy         = (r_state != S_IDLE);
  assign samples_done = r_samples;
  assign intr_pending = r_status & intr_en;
  assign irq          = r_irq;

endmodule

// File: doc/sampler_capture_ctrl.md
Name: sampler_capture_ctrl

Overview:
Sequencing and interrupt controller for the sampler/FIFO datapath in the AXISamplerWithFifo IP. It paces sample captures into the sample FIFO with a programmable period and sample count. It detects FIFO threshold and overflow conditions and runs the pending/ack/enable interrupt scheme that drives the IP's irq line. It sits between the AXI-lite register slaves, which provide the cfg_*, intr_* and global_en fields, and the FIFO write port.

Parameters:
DIV_WIDTH, 16, width of the sample-period divider
CNT_WIDTH, 16, width of the sample counter
LVL_WIDTH, 10, width of the FIFO fill-level and threshold fields

Ports:
ACLK  in  1  clock; all logic is on the rising edge
ARESETN  in  1  asynchronous active-low reset
cfg_start  in  1  single-cycle pulse that starts a capture run
cfg_abort  in  1  single-cycle pulse that aborts a run
cfg_period  in  DIV_WIDTH  clocks between captures minus 1
cfg_count  in  CNT_WIDTH  samples per run; 0 = continuous
cfg_thresh  in  LVL_WIDTH  FIFO level threshold
fifo_full  in  1  FIFO full flag
fifo_level  in  LVL_WIDTH  current FIFO fill level
fifo_wr_en  out  1  capture strobe to the FIFO write port
busy  out  1  high while a run is in progress
samples_done  out  CNT_WIDTH  samples written in the current/last run
intr_en  in  3  per-source interrupt enable: [0] done, [1] threshold, [2] overflow
intr_ack  in  3  per-source clear pulse, one bit per source
global_en  in  1  global interrupt enable
intr_pending  out  3  status & intr_en
irq  out  1  registered, active-high interrupt

Behaviour:
- Reset (ARESETN low, asynchronous): state=IDLE; busy=0; fifo_wr_en=0; samples_done=0; status=0; intr_pending=0; irq=0; divider=0.
- FSM states:
  - IDLE: on cfg_start (without cfg_abort) → RUN. Latch period P and count N, load divider=P, clear samples_done.
  - RUN: each cycle the divider decrements. At divider==0 a tick occurs and the divider reloads with P.
  - DONE: one cycle; sets status[0]; → IDLE.
- The latched P and N are used for the whole run. cfg_* changes during RUN have no effect.
- busy=1 in RUN and DONE, 0 in IDLE. busy rises the cycle after cfg_start is sampled.
- fifo_wr_en is combinational: RUN && tick && !fifo_full.
  - First strobe comes P+1 cycles after cfg_start is sampled, then one every P+1 cycles. P=0 gives a strobe every cycle.
- Tick with fifo_full=1: the sample is dropped, status[2] is set, samples_done does not increment, and the run continues.
- Each strobe increments samples_done (CNT_WIDTH bits, wraps in continuous mode).
  - N≠0: the strobe that makes samples_done==N → DONE next cycle. No further strobes.
  - N=0: runs until abort. status[0] is never set.
- cfg_abort in RUN → IDLE next cycle, no strobe that cycle, status[0] not set, samples_done held.
- cfg_abort and cfg_start together in IDLE: abort wins, stay IDLE.
- cfg_start in RUN/DONE is ignored.
- status[1] is set on the rising edge of (fifo_level >= cfg_thresh), compared against the previous cycle's value. This happens in any state.
- Status bits are sticky. intr_ack[i] clears status[i]. When a set and an ack hit the same bit in the same cycle, the set wins.
- intr_pending = status & intr_en (combinational).
- irq is registered: irq <= global_en & |intr_pending, so it follows pending with 1-cycle latency. It stays high until all enabled pending bits are acked or global_en=0.
- Asserting reset mid-run returns the block to the reset state immediately, even if a strobe is in progress.

Test Plan:
1. P=3, N=4, fifo_full=0, cfg_start → 4 strobes, 4 cycles apart, first 4 cycles after start; DONE; status[0]=1. With intr_en=1 and global_en=1, irq=1 one cycle later; samples_done=4.
2. Ack: after scenario 1, intr_ack=3'b001 → intr_pending=0, irq=0 the following cycle. Ack and done-set in the same cycle → status[0] stays 1.
3. Overflow: P=0, N=8, fifo_full forced high for ticks 3-4 → those ticks give no strobe; status[2]=1; run ends after 8 real strobes (10 ticks); samples_done=8.
4. Threshold: cfg_thresh=5, fifo_level ramps 3→7 and holds → status[1] is set once at the 4→5 step. Ack while the level is held at 7 → no re-set until the level drops below 5 and rises again.
5. Abort/continuous: P=1, N=0, run 20 cycles, then cfg_abort → exactly 10 strobes, IDLE next cycle, status[0]=0. Start and abort together in IDLE → busy stays 0.
6. Reset mid-run, plus gating: ARESETN low mid-run → fifo_wr_en, busy, irq, samples_done all 0 asynchronously. With global_en=0 and status set → irq=0 while intr_pending≠0.
